// File: rtl/afe_spi_pkg.sv
// Shared types and sizing helpers for the AFE SPI configuration sequencer.
package afe_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    GAP,
    LATCH
  } afe_state_e;

  // sysClk cycles per shift-clock phase, never fewer than two
  function automatic int calc_half(input int clk_rate, input int spi_rate);
    int h;
    h = clk_rate / (2 * spi_rate);
    return (h < 2) ? 2 : h;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int DEF_HALF  = calc_half(99999001, 1000000);
  localparam int DEF_PHASE_W = cnt_w(DEF_HALF);
  localparam int DEF_BIT_W = cnt_w(24);

endpackage

// File: rtl/afe_spi_phase_timer.sv
// Reloadable down-counter; tc is high while the count sits at zero.
module afe_spi_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/afe_spi_sequencer.sv
// Shifts one AFE configuration word MSB-first onto the selected SPI chain,
// then pulses that chain's latch enable.
module afe_spi_sequencer
  import afe_spi_pkg::*;
#(
  parameter int CLK_RATE      = 99999001,
  parameter int SPI_RATE      = 1000000,
  parameter int DATA_WIDTH    = 24,
  parameter int CHANNEL_COUNT = 2,
  parameter int LE_CYCLES     = 4,
  localparam int CH_W         = cnt_w(CHANNEL_COUNT)
) (
  input  logic                     sysClk,
  input  logic                     sysReset,
  input  logic                     cmdValid,
  output logic                     cmdReady,
  input  logic [CH_W-1:0]          cmdChannel,
  input  logic [DATA_WIDTH-1:0]    cmdData,
  output logic                     busy,
  output logic                     cmdError,
  output logic [15:0]              doneCount,
  output logic [CHANNEL_COUNT-1:0] AFE_SPI_CLK,
  output logic [CHANNEL_COUNT-1:0] AFE_SPI_SDI,
  output logic [CHANNEL_COUNT-1:0] AFE_SPI_LE
);

  localparam int HALF    = calc_half(CLK_RATE, SPI_RATE);
  localparam int BIT_W   = cnt_w(DATA_WIDTH);
  localparam int PHASE_W = cnt_w(HALF);
  localparam int TW      = max_i(PHASE_W, cnt_w(LE_CYCLES));

  afe_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [CH_W-1:0]         chan_q, chan_d;
  logic                    tmr_load, tmr_tc;
  logic [TW-1:0]           tmr_val;
  logic                    err_d, done_inc;
  logic [CHANNEL_COUNT-1:0] sel_d, clk_d, sdi_d, le_d;

  afe_spi_phase_timer #(.W(TW)) u_timer (
    .clk      (sysClk),
    .rst      (sysReset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    chan_d   = chan_q;
    tmr_load = 1'b0;
    tmr_val  = TW'(HALF - 1);
    err_d    = 1'b0;
    done_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmdValid && cmdReady) begin
          // Bad channels are consumed and flagged without touching any pin
          if (32'(cmdChannel) >= CHANNEL_COUNT) begin
            err_d = 1'b1;
          end else begin
            chan_d   = cmdChannel;
            shift_d  = cmdData;
            bit_d    = BIT_W'(DATA_WIDTH - 1);
            tmr_load = 1'b1;
            state_d  = LOW;
          end
        end
      end
      LOW: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          state_d  = HIGH;
        end
      end
      HIGH: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          if (bit_q == '0) begin
            state_d = GAP;
          end else begin
            shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
            bit_d   = bit_q - 1'b1;
            state_d = LOW;
          end
        end
      end
      GAP: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(LE_CYCLES - 1);
          state_d  = LATCH;
        end
      end
      LATCH: begin
        if (tmr_tc) begin
          done_inc = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pin values are derived from the next state so the outputs are registered
    for (int i = 0; i < CHANNEL_COUNT; i++)
      sel_d[i] = (32'(chan_d) == i);
    clk_d = (state_d == HIGH) ? sel_d : '0;
    sdi_d = ((state_d == LOW || state_d == HIGH) && shift_d[DATA_WIDTH-1]) ? sel_d : '0;
    le_d  = (state_d == LATCH) ? sel_d : '0;
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state_q     <= IDLE;
      cmdReady    <= 1'b1;
      busy        <= 1'b0;
      cmdError    <= 1'b0;
      doneCount   <= '0;
      AFE_SPI_CLK <= '0;
      AFE_SPI_SDI <= '0;
      AFE_SPI_LE  <= '0;
    end else begin
      state_q     <= state_d;
      cmdReady    <= (state_d == IDLE);
      busy        <= (state_d != IDLE);
      cmdError    <= err_d;
      doneCount   <= doneCount + {15'd0, done_inc};
      AFE_SPI_CLK <= clk_d;
      AFE_SPI_SDI <= sdi_d;
      AFE_SPI_LE  <= le_d;
    end
  end

  always_ff @(posedge sysClk) begin
    shift_q <= shift_d;
    bit_q   <= bit_d;
    chan_q  <= chan_d;
  end

endmodule

// File: tb/tb_afe_spi_sequencer.sv
// Scoreboard bench for afe_spi_sequencer with HALF=2, 8-bit words, 3 chains.
module tb_afe_spi_sequencer;

  localparam int DW  = 8;
  localparam int NCH = 3;

  logic           sysClk = 1'b0;
  logic           sysReset = 1'b1;
  logic           cmdValid = 1'b0;
  logic           cmdReady;
  logic [1:0]     cmdChannel = '0;
  logic [DW-1:0]  cmdData = '0;
  logic           busy, cmdError;
  logic [15:0]    doneCount;
  logic [NCH-1:0] AFE_SPI_CLK, AFE_SPI_SDI, AFE_SPI_LE;

  afe_spi_sequencer #(
    .CLK_RATE(4), .SPI_RATE(1), .DATA_WIDTH(DW), .CHANNEL_COUNT(NCH), .LE_CYCLES(3)
  ) dut (
    .sysClk(sysClk), .sysReset(sysReset), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdChannel(cmdChannel), .cmdData(cmdData), .busy(busy), .cmdError(cmdError),
    .doneCount(doneCount), .AFE_SPI_CLK(AFE_SPI_CLK), .AFE_SPI_SDI(AFE_SPI_SDI),
    .AFE_SPI_LE(AFE_SPI_LE)
  );

  always #5 sysClk = ~sysClk;

  int total = 0;
  int bad = 0;
  int exp_done = 0;

  typedef struct { int ch; int b; } bit_exp_t;
  typedef struct { int ch; int gap; } le_exp_t;
  typedef struct { int len; int done; } txn_exp_t;

  bit_exp_t bit_q[$];
  le_exp_t  le_q[$];
  txn_exp_t txn_q[$];

  function automatic void chk(string name, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic expect_bits(int ch, logic [DW-1:0] w, int nbits);
    bit_exp_t e;
    for (int i = DW - 1; i >= DW - nbits; i--) begin
      e.ch = ch;
      e.b  = int'(w[i]);
      bit_q.push_back(e);
    end
  endtask

  // Full transaction: 8 bits, LE after a 2-cycle gap, busy for 2*2*8+2+3 = 37
  task automatic expect_txn(int ch, logic [DW-1:0] w);
    le_exp_t  l;
    txn_exp_t t;
    expect_bits(ch, w, DW);
    exp_done = (exp_done + 1) % 65536;
    l.ch = ch; l.gap = 2;
    le_q.push_back(l);
    t.len = 37; t.done = exp_done;
    txn_q.push_back(t);
  endtask

  // Monitor: scores every shift-clock rise, LE pulse and completed transaction
  initial begin
    int cyc, busy_run, aborted, nact;
    int last_hi[NCH];
    int le_run[NCH];
    int le_gap[NCH];
    logic [NCH-1:0] prev_clk;
    bit_exp_t be;
    le_exp_t  le;
    txn_exp_t te;
    cyc = 0; busy_run = 0; aborted = 0; prev_clk = '0;
    for (int c = 0; c < NCH; c++) begin
      last_hi[c] = 0; le_run[c] = 0; le_gap[c] = 0;
    end
    forever begin
      @(negedge sysClk);
      cyc++;
      nact = 0;
      for (int c = 0; c < NCH; c++) begin
        if (AFE_SPI_CLK[c] || AFE_SPI_SDI[c] || AFE_SPI_LE[c]) nact++;
        if (AFE_SPI_CLK[c] && !prev_clk[c]) begin
          if (bit_q.size() == 0) begin
            chk("unexpected_clk_rise", 1, 0);
          end else begin
            be = bit_q.pop_front();
            chk("bit_chain", c, be.ch);
            chk("bit_sdi", int'(AFE_SPI_SDI[c]), be.b);
          end
        end
        if (AFE_SPI_CLK[c]) last_hi[c] = cyc;
        if (AFE_SPI_LE[c]) begin
          if (le_run[c] == 0) le_gap[c] = cyc - last_hi[c] - 1;
          le_run[c]++;
        end else if (le_run[c] > 0) begin
          if (le_q.size() == 0) begin
            chk("unexpected_le", 1, 0);
          end else begin
            le = le_q.pop_front();
            chk("le_chain", c, le.ch);
            chk("le_width", le_run[c], 3);
            chk("gap_width", le_gap[c], le.gap);
          end
          le_run[c] = 0;
        end
      end
      prev_clk = AFE_SPI_CLK;
      if (busy || nact != 0) begin
        chk("single_active_chain", int'(nact <= 1), 1);
        chk("chain2_idle", {AFE_SPI_CLK[2], AFE_SPI_SDI[2], AFE_SPI_LE[2]}, 0);
      end
      if (sysReset && (busy || busy_run > 0)) aborted = 1;
      if (busy) begin
        busy_run++;
      end else if (busy_run > 0) begin
        if (!aborted) begin
          if (txn_q.size() == 0) begin
            chk("unexpected_txn_end", 1, 0);
          end else begin
            te = txn_q.pop_front();
            chk("busy_length", busy_run, te.len);
            chk("done_count", doneCount, te.done);
          end
        end
        busy_run = 0;
        aborted = 0;
      end
    end
  end

  task automatic issue(int ch, logic [DW-1:0] d);
    int n;
    cmdValid = 1'b1;
    cmdChannel = ch[1:0];
    cmdData = d;
    n = 0;
    while (!cmdReady && n < 200) begin
      @(negedge sysClk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 0, 1);
    @(negedge sysClk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge sysClk);
      n++;
    end
    if (n >= 300) chk("idle_timeout", 0, 1);
    @(negedge sysClk);
  endtask

  task automatic do_reset();
    sysReset = 1'b1;
    repeat (2) @(negedge sysClk);
    sysReset = 1'b0;
    exp_done = 0;
    @(negedge sysClk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rises;
    logic prev;

    repeat (3) @(negedge sysClk);
    chk("rst_cmdReady", cmdReady, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cmdError", cmdError, 0);
    chk("rst_doneCount", doneCount, 0);
    chk("rst_pins", {AFE_SPI_CLK, AFE_SPI_SDI, AFE_SPI_LE}, 0);
    sysReset = 1'b0;
    @(negedge sysClk);

    // Single write 0xA5 to chain 1
    expect_txn(1, 8'hA5);
    issue(1, 8'hA5);
    cmdValid = 1'b0;
    chk("t1_busy_after_accept", busy, 1);
    chk("t1_ready_after_accept", cmdReady, 0);
    wait_idle();
    chk("t1_doneCount", doneCount, 1);

    // Back-to-back with cmdValid held
    do_reset();
    expect_txn(0, 8'h81);
    expect_txn(1, 8'h7E);
    issue(0, 8'h81);
    cmdChannel = 2'd1;
    cmdData = 8'h7E;
    n = 0;
    while (!cmdReady && n < 200) begin
      @(negedge sysClk);
      n++;
    end
    if (n >= 200) chk("t2_ready_timeout", 0, 1);
    @(negedge sysClk);
    chk("t2_second_accept_busy", busy, 1);
    chk("t2_second_accept_ready", cmdReady, 0);
    cmdValid = 1'b0;
    wait_idle();
    chk("t2_doneCount", doneCount, 2);

    // Out-of-range channel
    issue(3, 8'h55);
    cmdValid = 1'b0;
    chk("t3_cmdError_pulse", cmdError, 1);
    chk("t3_busy", busy, 0);
    chk("t3_ready", cmdReady, 1);
    chk("t3_pins", {AFE_SPI_CLK, AFE_SPI_SDI, AFE_SPI_LE}, 0);
    @(negedge sysClk);
    chk("t3_cmdError_clear", cmdError, 0);
    chk("t3_ready_next", cmdReady, 1);
    chk("t3_busy_next", busy, 0);
    chk("t3_doneCount", doneCount, 2);
    chk("t3_pins_next", {AFE_SPI_CLK, AFE_SPI_SDI, AFE_SPI_LE}, 0);

    // Reset after the 4th rising edge of a 0xFF write
    expect_bits(0, 8'hFF, 4);
    issue(0, 8'hFF);
    cmdValid = 1'b0;
    rises = 0; n = 0; prev = AFE_SPI_CLK[0];
    while (rises < 4 && n < 200) begin
      @(negedge sysClk);
      if (AFE_SPI_CLK[0] && !prev) rises++;
      prev = AFE_SPI_CLK[0];
      n++;
    end
    if (n >= 200) chk("t4_rise_timeout", 0, 1);
    sysReset = 1'b1;
    @(negedge sysClk);
    chk("t4_pins", {AFE_SPI_CLK, AFE_SPI_SDI, AFE_SPI_LE}, 0);
    chk("t4_busy", busy, 0);
    chk("t4_ready", cmdReady, 1);
    chk("t4_doneCount", doneCount, 0);
    @(negedge sysClk);
    sysReset = 1'b0;
    exp_done = 0;
    @(negedge sysClk);
    expect_txn(0, 8'h3C);
    issue(0, 8'h3C);
    cmdValid = 1'b0;
    wait_idle();
    chk("t4_doneCount_after", doneCount, 1);

    // Input changes while busy are ignored
    expect_txn(1, 8'hC3);
    issue(1, 8'hC3);
    cmdValid = 1'b0;
    repeat (5) @(negedge sysClk);
    cmdData = 8'h00;
    cmdChannel = 2'd0;
    wait_idle();
    chk("t5_doneCount", doneCount, 2);

    // doneCount wrap from 0xFFFF
    force dut.doneCount = 16'hFFFF;
    @(negedge sysClk);
    release dut.doneCount;
    @(negedge sysClk);
    chk("t6_preload", doneCount, 16'hFFFF);
    exp_done = 16'hFFFF;
    expect_txn(0, 8'h5A);
    issue(0, 8'h5A);
    cmdValid = 1'b0;
    wait_idle();
    chk("t6_wrap", doneCount, 0);

    repeat (3) @(negedge sysClk);
    chk("bits_left", bit_q.size(), 0);
    chk("le_left", le_q.size(), 0);
    chk("txn_left", txn_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
